// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings for the pipeline hazard/control sequencer: FSM states,
// PC-load select codes, the NOP opcode and the per-state output decode.
package hazard_ctrl_unit_pkg;

    typedef enum logic [3:0] {
        S_RUN      = 4'd0,
        S_FSTALL   = 4'd1,
        S_DSTALL   = 4'd2,
        S_RET_WAIT = 4'd3,
        S_RET_LOAD = 4'd4,
        S_INT_LOAD = 4'd5,
        S_HALT     = 4'd6
    } state_t;

    typedef enum logic [1:0] {
        PCSEL_INC = 2'b00,
        PCSEL_INT = 2'b01,
        PCSEL_RET = 2'b10
    } pcsel_t;

    localparam logic [31:0] NOP_OPCODE = 32'h0000_0000;

    // Registered control word; 'normal' means the stalls follow the live requests.
    typedef struct packed {
        logic   normal;
        logic   stall_fetch;
        logic   stall_decode;
        pcsel_t pc_sel;
        logic   inst_sel;
    } ctrl_t;

    function automatic ctrl_t decode_outputs(state_t s);
        ctrl_t c;
        c = '{normal: 1'b1, stall_fetch: 1'b0, stall_decode: 1'b0,
              pc_sel: PCSEL_INC, inst_sel: 1'b0};
        case (s)
            S_RET_WAIT: c = '{1'b0, 1'b1, 1'b0, PCSEL_INC, 1'b1};
            S_RET_LOAD: c = '{1'b0, 1'b0, 1'b0, PCSEL_RET, 1'b1};
            S_INT_LOAD: c = '{1'b0, 1'b0, 1'b0, PCSEL_INT, 1'b1};
            S_HALT:     c = '{1'b0, 1'b1, 1'b1, PCSEL_INC, 1'b1};
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Event/control bundle between the datapath and the hazard sequencer.
// 'ret' carries the return-detected event (return is a reserved word).
interface hazard_ctrl_unit_if #(
    parameter int PC_WIDTH   = 16,
    parameter int INST_WIDTH = 32
);
    logic                  ret;
    logic                  halt;
    logic                  fetch_stl_req;
    logic                  dec_stl_req;
    logic                  interrupt;
    logic [PC_WIDTH-1:0]   interrupt_vector_address;

    logic                  stall_fetch;
    logic                  stall_decode;
    logic [1:0]            prog_cntr_load_sel;
    logic                  inst_word_sel;
    logic [INST_WIDTH-1:0] new_inst_word;
    logic [PC_WIDTH-1:0]   prog_cntr_int_addr;
    logic [3:0]            state;

    modport master (
        output ret, halt, fetch_stl_req, dec_stl_req, interrupt, interrupt_vector_address,
        input  stall_fetch, stall_decode, prog_cntr_load_sel, inst_word_sel,
               new_inst_word, prog_cntr_int_addr, state
    );

    modport slave (
        input  ret, halt, fetch_stl_req, dec_stl_req, interrupt, interrupt_vector_address,
        output stall_fetch, stall_decode, prog_cntr_load_sel, inst_word_sel,
               new_inst_word, prog_cntr_int_addr, state
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/control sequencer: turns stall, return, halt and interrupt
// events into fetch/decode stalls, PC-load selection and NOP injection.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int                    PC_WIDTH         = 16,
    parameter int                    INST_WIDTH       = 32,
    parameter logic [INST_WIDTH-1:0] NOP_WORD         = INST_WIDTH'(NOP_OPCODE),
    parameter int                    RET_FLUSH_CYCLES = 3
) (
    input  logic              clock,
    input  logic              nreset,
    hazard_ctrl_unit_if.slave bus
);

    localparam int CNT_W = (RET_FLUSH_CYCLES > 1) ? $clog2(RET_FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RET_FLUSH_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [PC_WIDTH-1:0] vec_q, vec_d;
    ctrl_t               ctrl_q;

    // NOTE: every always_comb target gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        vec_d   = vec_q;
        case (state_q)
            S_RUN, S_FSTALL, S_DSTALL: begin
                if (bus.interrupt) begin
                    state_d = S_INT_LOAD;
                    vec_d   = bus.interrupt_vector_address;
                end else if (bus.halt) begin
                    state_d = S_HALT;
                end else if (bus.ret) begin
                    state_d = S_RET_WAIT;
                    cnt_d   = CNT_INIT;
                end else if (bus.dec_stl_req) begin
                    state_d = S_DSTALL;
                end else if (bus.fetch_stl_req) begin
                    state_d = S_FSTALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RET_WAIT: begin
                // The return flush is not abortable; an interrupt is parked until it finishes.
                if (bus.interrupt) begin
                    pend_d = 1'b1;
                    vec_d  = bus.interrupt_vector_address;
                end
                if (cnt_q == '0) begin
                    state_d = S_RET_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RET_LOAD: state_d = pend_q ? S_INT_LOAD : S_RUN;
            S_INT_LOAD: begin
                pend_d  = 1'b0;
                state_d = S_RUN;
            end
            S_HALT: begin
                if (bus.interrupt) begin
                    state_d = S_INT_LOAD;
                    vec_d   = bus.interrupt_vector_address;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            vec_q   <= '0;
            ctrl_q  <= decode_outputs(S_RUN);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            ctrl_q  <= decode_outputs(state_d);
        end
    end

    // Normal-group stalls pass the live requests straight through with no latency.
    assign bus.stall_fetch        = ctrl_q.normal ? (bus.fetch_stl_req | bus.dec_stl_req)
                                                  : ctrl_q.stall_fetch;
    assign bus.stall_decode       = ctrl_q.normal ? bus.dec_stl_req : ctrl_q.stall_decode;
    assign bus.prog_cntr_load_sel = ctrl_q.pc_sel;
    assign bus.inst_word_sel      = ctrl_q.inst_sel;
    assign bus.new_inst_word      = NOP_WORD;
    assign bus.prog_cntr_int_addr = vec_q;
    assign bus.state              = state_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios then random events,
// predicted by a behavioural model and checked by a decoupled negedge monitor.
module tb_hazard_ctrl_unit;

    localparam int RFC = 3;

    logic clk = 1'b0;
    logic nreset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hazard_ctrl_unit_if #(.PC_WIDTH(16), .INST_WIDTH(32)) bus ();

    hazard_ctrl_unit #(
        .PC_WIDTH(16), .INST_WIDTH(32), .NOP_WORD(32'h0), .RET_FLUSH_CYCLES(RFC)
    ) dut (
        .clock (clk),
        .nreset(nreset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic        sf;
        logic        sd;
        logic [1:0]  sel;
        logic        iws;
        logic [31:0] niw;
        logic [15:0] ia;
        logic [3:0]  st;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: mode number, flush cycles still to spend, parked interrupt.
    int          m_mode = 0;
    int          m_left = 0;
    bit          m_pend = 0;
    logic [15:0] m_vec  = 16'h0;

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, required %h", name, c, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state",        e.cyc, 32'(bus.state),              32'(e.st));
            check("stall_fetch",  e.cyc, 32'(bus.stall_fetch),        32'(e.sf));
            check("stall_decode", e.cyc, 32'(bus.stall_decode),       32'(e.sd));
            check("load_sel",     e.cyc, 32'(bus.prog_cntr_load_sel), 32'(e.sel));
            check("inst_sel",     e.cyc, 32'(bus.inst_word_sel),      32'(e.iws));
            check("nop_word",     e.cyc, bus.new_inst_word,           e.niw);
            check("int_addr",     e.cyc, 32'(bus.prog_cntr_int_addr), 32'(e.ia));
        end
    end

    // Apply one cycle of inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic rn, input logic r, input logic h, input logic f,
                        input logic d, input logic i, input logic [15:0] v);
        exp_t e;
        nreset = rn; bus.ret = r; bus.halt = h; bus.fetch_stl_req = f;
        bus.dec_stl_req = d; bus.interrupt = i; bus.interrupt_vector_address = v;

        e.cyc = cyc; e.niw = 32'h0; e.ia = m_vec; e.st = 4'(m_mode);
        e.sf = 1'b0; e.sd = 1'b0; e.sel = 2'b00; e.iws = 1'b1;
        case (m_mode)
            0, 1, 2: begin e.sf = f | d; e.sd = d; e.iws = 1'b0; end
            3:       e.sf = 1'b1;
            4:       e.sel = 2'b10;
            5:       e.sel = 2'b01;
            6:       begin e.sf = 1'b1; e.sd = 1'b1; end
            default: ;
        endcase
        exp_q.push_back(e);

        if (!rn) begin
            m_mode = 0; m_left = 0; m_pend = 0; m_vec = 16'h0;
        end else begin
            case (m_mode)
                0, 1, 2: begin
                    if (i)      begin m_mode = 5; m_vec = v; end
                    else if (h) m_mode = 6;
                    else if (r) begin m_mode = 3; m_left = RFC; end
                    else if (d) m_mode = 2;
                    else if (f) m_mode = 1;
                    else        m_mode = 0;
                end
                3: begin
                    if (i) begin m_pend = 1; m_vec = v; end
                    m_left--;
                    if (m_left == 0) m_mode = 4;
                end
                4: m_mode = m_pend ? 5 : 0;
                5: begin m_pend = 0; m_mode = 0; end
                6: if (i) begin m_mode = 5; m_vec = v; end
                default: m_mode = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        nreset = 1'b0; bus.ret = 0; bus.halt = 0; bus.fetch_stl_req = 0;
        bus.dec_stl_req = 0; bus.interrupt = 0; bus.interrupt_vector_address = '0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 16'h0);

        // Stall pass-through
        step(1, 0, 0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 1, 0, 0, 16'h0);
        idle(1);
        step(1, 0, 0, 0, 1, 0, 16'h0);
        step(1, 0, 0, 1, 1, 0, 16'h0);
        idle(2);
        // Return flush
        step(1, 1, 0, 0, 0, 0, 16'h0);
        idle(6);
        // Interrupt from run
        step(1, 0, 0, 0, 0, 1, 16'h0040);
        idle(2);
        // Halt then interrupt exit
        step(1, 0, 1, 0, 0, 0, 16'h0);
        idle(10);
        step(1, 0, 0, 1, 1, 1, 16'h0100);
        idle(2);
        // Interrupt parked during return flush
        step(1, 1, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 1, 16'h0080);
        idle(6);
        // Reset mid-flush with parked interrupt
        step(1, 1, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 1, 16'h1234);
        step(0, 0, 0, 0, 0, 0, 16'h0);
        idle(6);
        // Simultaneous events resolved by priority
        step(1, 1, 1, 1, 1, 1, 16'hBEEF);
        idle(2);
        step(1, 1, 1, 1, 1, 0, 16'h0);
        step(1, 0, 0, 0, 0, 1, 16'h00AA);
        idle(2);
        step(1, 1, 0, 1, 1, 0, 16'h0);
        idle(5);

        for (int k = 0; k < 3000; k++) begin
            logic [15:0] v;
            v = 16'($urandom_range(0, 65535));
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 8),  ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 8),  v);
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
